// File: rtl/aes_128_inv_pkg.sv
// Shared types and constants for the AES-128 inverse-cipher round controller.
package aes_128_inv_pkg;

   localparam int NR            = 10;
   localparam int CLK_PER_ROUND = 3;
   localparam int ROUND_CNT_MAX = 29;
   localparam int KEY_ADDR_W    = 4;
   localparam int CNT_W         = 5;

   typedef enum logic [2:0] {
      IDLE,
      KEXP,
      INIT,
      ROUND,
      DONE
   } state_t;

endpackage

// File: rtl/aes_128_inv_control_3clk_if.sv
// Request/status and round-key store handshake between the controller and its datapath.
interface aes_128_inv_control_3clk_if;

   logic                                  in_en;
   logic                                  new_key;
   logic                                  key_step;
   logic                                  key_wr_en;
   logic                                  key_rd_en;
   logic [aes_128_inv_pkg::KEY_ADDR_W-1:0] key_addr;
   logic                                  en_invmixcol;
   logic                                  busy;
   logic                                  out_en;
   logic                                  in_en_collision_irq_pulse;

   modport master (
      output in_en, new_key,
      input  key_step, key_wr_en, key_rd_en, key_addr,
             en_invmixcol, busy, out_en, in_en_collision_irq_pulse
   );

   modport slave (
      input  in_en, new_key,
      output key_step, key_wr_en, key_rd_en, key_addr,
             en_invmixcol, busy, out_en, in_en_collision_irq_pulse
   );

endinterface

// File: rtl/aes_128_round_timer.sv
// Free-running 0..29 round counter with a mod-3 phase and a round index (0..9).
module aes_128_round_timer
   import aes_128_inv_pkg::*;
(
   input  logic                  clk,
   input  logic                  kill_n,
   input  logic                  i_clr,
   output logic [CNT_W-1:0]      o_count,
   output logic [KEY_ADDR_W-1:0] o_round_idx,
   output logic                  o_phase0,
   output logic                  o_phase2
);

   logic [CNT_W-1:0]      r_count;
   logic [1:0]            r_phase;
   logic [KEY_ADDR_W-1:0] r_round_idx;

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (!kill_n || i_clr) begin
         r_count     <= '0;
         r_phase     <= '0;
         r_round_idx <= '0;
      end else begin
         r_count <= (r_count == CNT_W'(ROUND_CNT_MAX)) ? '0 : r_count + CNT_W'(1);
         if (r_phase == 2'(CLK_PER_ROUND - 1)) begin
            r_phase     <= '0;
            r_round_idx <= (r_round_idx == KEY_ADDR_W'(NR - 1)) ? '0 : r_round_idx + KEY_ADDR_W'(1);
         end else begin
            r_phase <= r_phase + 2'd1;
         end
      end
   end

   assign o_count     = r_count;
   assign o_round_idx = r_round_idx;
   assign o_phase0    = (r_phase == 2'd0);
   assign o_phase2    = (r_phase == 2'(CLK_PER_ROUND - 1));

endmodule

// File: rtl/aes_128_inv_control_3clk.sv
// AES-128 decryption sequencer: optional key expansion, initial AddRoundKey, 10 rounds of 3 clocks.
// Optional key caching across requests is enabled by defining AES_INV_KEY_CACHE_EN.
module aes_128_inv_control_3clk
   import aes_128_inv_pkg::*;
(
   input  logic                          clk,
   input  logic                          kill_n,
   aes_128_inv_control_3clk_if.slave     bus
);

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_timer_clr;
   logic [CNT_W-1:0]      w_count;
   logic [KEY_ADDR_W-1:0] w_round_idx;
   logic                  w_phase0;
   logic                  w_phase2;
   logic                  w_cnt_last;
   logic                  w_busy;
   logic                  w_need_kexp;
   logic                  r_collision;

   aes_128_round_timer u_timer (
      .clk         (clk),
      .kill_n      (kill_n),
      .i_clr       (w_timer_clr),
      .o_count     (w_count),
      .o_round_idx (w_round_idx),
      .o_phase0    (w_phase0),
      .o_phase2    (w_phase2)
   );

   assign w_cnt_last = (w_count == CNT_W'(ROUND_CNT_MAX));
   assign w_busy     = (r_state == KEXP) || (r_state == INIT) || (r_state == ROUND);

`ifdef AES_INV_KEY_CACHE_EN
   logic r_key_cached;

   // Only a completed expansion marks the store valid; a kill mid-expansion leaves it invalid.
   always_ff @(posedge clk) begin
      if (!kill_n) begin
         r_key_cached <= 1'b0;
      end else if (r_state == KEXP && w_cnt_last) begin
         r_key_cached <= 1'b1;
      end
   end

   assign w_need_kexp = bus.new_key | ~r_key_cached;
`else
   // Without a cache every request re-expands, whatever new_key says.
   assign w_need_kexp = bus.new_key | 1'b1;
`endif

   always_ff @(posedge clk) begin
      if (!kill_n) begin
         r_state     <= IDLE;
         r_collision <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_collision <= bus.in_en & w_busy;
      end
   end

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (bus.in_en) w_state_nxt = w_need_kexp ? KEXP : INIT;
         KEXP:    if (w_cnt_last) w_state_nxt = INIT;
         INIT:    w_state_nxt = ROUND;
         ROUND:   if (w_cnt_last) w_state_nxt = DONE;
         DONE:    w_state_nxt = bus.in_en ? (w_need_kexp ? KEXP : INIT) : IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   // The counter restarts on every entry to a counted state, including DONE -> KEXP.
   assign w_timer_clr = ((w_state_nxt == KEXP)  && (r_state != KEXP)) ||
                        ((w_state_nxt == ROUND) && (r_state != ROUND));

   always_comb begin
      bus.key_step     = 1'b0;
      bus.key_wr_en    = 1'b0;
      bus.key_rd_en    = 1'b0;
      bus.key_addr     = '0;
      bus.en_invmixcol = 1'b0;
      case (r_state)
         KEXP: begin
            bus.key_step = w_phase0;
            if (w_count == '0) begin
               bus.key_wr_en = 1'b1;
            end else if (w_phase2) begin
               bus.key_wr_en = 1'b1;
               bus.key_addr  = w_round_idx + KEY_ADDR_W'(1);
            end
         end
         INIT: begin
            bus.key_rd_en = 1'b1;
            bus.key_addr  = KEY_ADDR_W'(NR);
         end
         ROUND: begin
            if (w_phase0) begin
               bus.key_rd_en = 1'b1;
               bus.key_addr  = KEY_ADDR_W'(NR - 1) - w_round_idx;
            end
            // The last round skips InvMixColumns.
            bus.en_invmixcol = (w_count <= CNT_W'(ROUND_CNT_MAX - CLK_PER_ROUND));
         end
         default: ;
      endcase
   end

   assign bus.busy                      = w_busy;
   assign bus.out_en                    = (r_state == DONE);
   assign bus.in_en_collision_irq_pulse = r_collision;

endmodule

// File: tb/tb_aes_128_inv_control_3clk.sv
// Directed bench for aes_128_inv_control_3clk; expectations follow the build's key-cache setting.
module tb_aes_128_inv_control_3clk;

   logic clk = 1'b0;
   logic kill_n;
   int   tests_run = 0;
   int   fail_cnt  = 0;
   bit   tb_cached = 1'b0;

   localparam int LAT_LIMIT = 100;

   aes_128_inv_control_3clk_if bus ();

   aes_128_inv_control_3clk dut (
      .clk    (clk),
      .kill_n (kill_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout required completion");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      assert (obs === exp) else begin
         fail_cnt++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // Caller has just driven in_en=1 / new_key=nk at a negedge; samples taken on negedges.
   task automatic run_op(input string name, input bit nk, input int coll_n, input bit chain);
      bit exp_kexp;
      int lat = 0, steps = 0, wrs = 0, wr_bad = 0, rds = 0, rd_bad = 0, rd_first = 0;
      int imc_hi = 0, imc_tail = 0, busy_bad = 0, excl_bad = 0, irq_cnt = 0, irq_n = 0;
`ifdef AES_INV_KEY_CACHE_EN
      exp_kexp = nk || !tb_cached;
`else
      exp_kexp = 1'b1;
`endif
      for (int n = 1; n <= LAT_LIMIT; n++) begin
         @(negedge clk);
         if (n == 1 || n == coll_n + 1) bus.in_en = 1'b0;
         if (bus.key_step === 1'b1) steps++;
         if (bus.key_wr_en === 1'b1) begin
            if (bus.key_addr !== 4'(wrs)) wr_bad++;
            wrs++;
         end
         if (bus.key_rd_en === 1'b1) begin
            if (rds == 0) rd_first = n;
            if (bus.key_addr !== 4'(10 - rds)) rd_bad++;
            rds++;
         end
         if (bus.key_wr_en === 1'b1 && bus.key_rd_en === 1'b1) excl_bad++;
         if (bus.key_wr_en !== 1'b1 && bus.key_rd_en !== 1'b1 && bus.key_addr !== 4'd0) excl_bad++;
         if (bus.en_invmixcol === 1'b1) begin
            imc_hi++;
            imc_tail = 0;
         end else if (imc_hi > 0 && bus.busy === 1'b1) begin
            imc_tail++;
         end
         if (bus.in_en_collision_irq_pulse === 1'b1) begin
            irq_cnt++;
            irq_n = n;
         end
         if (bus.out_en === 1'b1) begin
            lat = n;
            if (bus.busy !== 1'b0) busy_bad++;
            if (chain) begin
               bus.in_en   = 1'b1;
               bus.new_key = 1'b0;
            end
            break;
         end else if (bus.busy !== 1'b1) begin
            busy_bad++;
         end
         if (n == coll_n) begin
            bus.in_en   = 1'b1;
            bus.new_key = 1'b1;
         end
      end
      check({name, " latency"},       lat,      exp_kexp ? 62 : 32);
      check({name, " key_step cnt"},  steps,    exp_kexp ? 10 : 0);
      check({name, " key_wr cnt"},    wrs,      exp_kexp ? 11 : 0);
      check({name, " key_wr addr"},   wr_bad,   0);
      check({name, " key_rd cnt"},    rds,      11);
      check({name, " key_rd addr"},   rd_bad,   0);
      check({name, " first rd cyc"},  rd_first, exp_kexp ? 31 : 1);
      check({name, " imc high cyc"},  imc_hi,   27);
      check({name, " imc low tail"},  imc_tail, 3);
      check({name, " busy shape"},    busy_bad, 0);
      check({name, " wr/rd/addr"},    excl_bad, 0);
      check({name, " irq count"},     irq_cnt,  (coll_n > 0) ? 1 : 0);
      if (coll_n > 0) check({name, " irq cycle"}, irq_n, coll_n + 1);
`ifdef AES_INV_KEY_CACHE_EN
      if (exp_kexp && lat != 0) tb_cached = 1'b1;
`endif
   endtask

   initial begin
      kill_n      = 1'b0;
      bus.in_en   = 1'b0;
      bus.new_key = 1'b0;
      repeat (3) @(negedge clk);
      check("reset busy",      bus.busy,                      0);
      check("reset out_en",    bus.out_en,                    0);
      check("reset key_wr",    bus.key_wr_en,                 0);
      check("reset key_rd",    bus.key_rd_en,                 0);
      check("reset key_addr",  bus.key_addr,                  0);
      check("reset irq",       bus.in_en_collision_irq_pulse, 0);
      check("reset imc",       bus.en_invmixcol,              0);
      kill_n = 1'b1;
      repeat (2) @(negedge clk);

      // Fresh key: full expansion.
      bus.in_en   = 1'b1;
      bus.new_key = 1'b1;
      run_op("opA", 1'b1, 0, 1'b0);

      // Same key; collision at ROUND round_count 12, then a request in the DONE cycle.
      @(negedge clk);
      bus.in_en   = 1'b1;
`ifdef AES_INV_KEY_CACHE_EN
      bus.new_key = 1'b0;
      run_op("opB", 1'b0, 14, 1'b1);
`else
      bus.new_key = 1'b0;
      run_op("opB", 1'b0, 44, 1'b1);
`endif
      run_op("opC", 1'b0, 0, 1'b0);

      // Kill during KEXP round_count 15.
      @(negedge clk);
      bus.in_en   = 1'b1;
      bus.new_key = 1'b1;
      @(negedge clk);
      bus.in_en = 1'b0;
      repeat (15) @(negedge clk);
      check("pre-kill busy", bus.busy, 1);
      kill_n = 1'b0;
      @(negedge clk);
      kill_n = 1'b1;
      tb_cached = 1'b0;
      check("kill busy",     bus.busy,      0);
      check("kill key_step", bus.key_step,  0);
      check("kill key_wr",   bus.key_wr_en, 0);

      // Reset wins over a simultaneous request.
      kill_n    = 1'b0;
      bus.in_en = 1'b1;
      @(negedge clk);
      kill_n    = 1'b1;
      bus.in_en = 1'b0;
      check("prio busy", bus.busy, 0);
      @(negedge clk);
      check("prio idle", bus.busy, 0);

      // Cache was cleared by the kill, so this must expand again.
      bus.in_en   = 1'b1;
      bus.new_key = 1'b0;
      run_op("opD", 1'b0, 0, 1'b0);

      repeat (2) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests_run, fail_cnt);
      $finish;
   end

endmodule

// File: doc/aes_128_inv_control_3clk.md
AES_128_INV_CONTROL_3CLK -- requirements
Module: aes_128_inv_control_3clk

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all logic on posedge.
REQ-002 SHALL have port kill_n, input, 1, synchronous active-low reset.
REQ-003 SHALL have port in_en, input, 1, one-cycle request to decrypt the presented ciphertext.
REQ-004 SHALL have port new_key, input, 1, sampled with in_en; high means the key input changed.
REQ-005 SHALL have port key_step, output, 1, pulse advancing the external forward key-expansion core.
REQ-006 SHALL have port key_wr_en, output, 1, write strobe into the round-key store.
REQ-007 SHALL have port key_rd_en, output, 1, read strobe from the round-key store.
REQ-008 SHALL have port key_addr, output, 4, round-key index 0..10 for key_wr_en or key_rd_en.
REQ-009 SHALL have port en_invmixcol, output, 1, high means the datapath applies InvMixColumns.
REQ-010 SHALL have port busy, output, 1, high from request acceptance until the out_en cycle.
REQ-011 SHALL have port out_en, output, 1, one-cycle plaintext-valid pulse.
REQ-012 SHALL have port in_en_collision_irq_pulse, output, 1, one-cycle pulse when in_en arrives while busy.

Function
REQ-013 SHALL implement FSM states IDLE, KEXP, INIT, ROUND, DONE.
REQ-014 SHALL use round_count 0..29, cleared on entry to KEXP and ROUND and incremented each cycle; wraps to 0 after 29.
REQ-015 IDLE: in_en with (new_key or not key_cached) SHALL go to KEXP; in_en otherwise SHALL go to INIT; no in_en SHALL stay in IDLE.
REQ-016 KEXP: key_step SHALL pulse at round_count 0,3,...,27.
REQ-017 KEXP: key_wr_en SHALL pulse with key_addr=0 at round_count 0, and with key_addr=(round_count+1)/3 at round_count 2,5,...,29.
REQ-018 KEXP: at round_count 29, SHALL set key_cached and go to INIT.
REQ-019 INIT: SHALL last one cycle, with key_rd_en=1 and key_addr=10 for the initial AddRoundKey, then go to ROUND.
REQ-020 ROUND: key_rd_en SHALL pulse at round_count 3(r-1) with key_addr=10-r for r=1..10.
REQ-021 ROUND: en_invmixcol SHALL be 1 for round_count 0..26 and 0 for 27..29; it SHALL be 0 in all other states.
REQ-022 ROUND: at round_count 29, SHALL go to DONE.
REQ-023 DONE: SHALL assert out_en for one cycle, drop busy in the same cycle, and return to IDLE.
REQ-024 Latency, in_en sampled at cycle T: cached key gives out_en at T+32; expansion gives out_en at T+62.
REQ-025 busy SHALL be 1 in KEXP, INIT and ROUND, and 0 in IDLE and DONE.
REQ-026 in_en while busy SHALL be ignored (no restart, no state change) and SHALL produce in_en_collision_irq_pulse=1 on the next cycle.
REQ-027 in_en in the DONE cycle SHALL be accepted as a new request, with back-to-back operation and no gap cycle.
REQ-028 key_wr_en and key_rd_en SHALL never be high together; key_addr SHALL be 0 when neither is high.

Reset
REQ-029 kill_n=0 at a clock edge SHALL force state IDLE, round_count 0, key_cached 0, and all outputs 0, regardless of state.
REQ-030 Reset during KEXP SHALL leave key_cached 0, so the next request re-expands the key.
REQ-031 Reset SHALL take priority over in_en in the same cycle.

Configuration
REQ-032 Macro AES_INV_KEY_CACHE_EN defined SHALL enable key_cached behaviour as above.
REQ-033 With AES_INV_KEY_CACHE_EN undefined, every accepted in_en SHALL go to KEXP, new_key SHALL be ignored, and latency SHALL always be 62 cycles.

Structure
REQ-034 Package aes_128_inv_pkg SHALL hold the state enum and constants NR=10, CLK_PER_ROUND=3, ROUND_CNT_MAX=29, KEY_ADDR_W=4.
REQ-035 Sub-module aes_128_round_timer SHALL contain the round_count counter with clear and phase-0 and phase-2 strobes; the FSM stays in the top module.

Verification
REQ-036 Reset, then in_en with new_key=1 at T -> 11 key_wr_en pulses (addr 0..10), key_rd_en addr 10 at T+31, out_en at T+62.
REQ-037 Second in_en with new_key=0 (cached) -> no key_step; key_rd_en addr sequence 10,9,...,0; out_en exactly 32 cycles after in_en.
REQ-038 in_en at round_count 12 of ROUND -> in_en_collision_irq_pulse the next cycle; out_en timing unchanged.
REQ-039 kill_n=0 at KEXP round_count 15, then in_en new_key=0 -> KEXP is entered (key_cached was cleared); out_en at +62.
REQ-040 in_en in the DONE cycle -> accepted; next out_en 32 cycles later; en_invmixcol low exactly 3 cycles per operation in the final round.
REQ-041 Build without AES_INV_KEY_CACHE_EN, two requests with new_key=0 -> both run KEXP; both show 62-cycle latency.
